// File: rtl/dm_pkg.sv
// Shared types and helpers for the synchronous data memory (dm_sync).
package dm_pkg;

  typedef enum logic [1:0] {
    CLEAR = 2'd0,
    IDLE  = 2'd1,
    RD    = 2'd2,
    WR    = 2'd3
  } state_t;

  localparam int WAIT_CNT_W = 4;

  // Even parity bit over a zero-extended word; zero padding leaves the XOR unchanged.
  function automatic logic parity_even(input logic [63:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/dm_sync_ram_array.sv
// Storage array for dm_sync: one write port and one registered read port.
module dm_ram_array #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write port; callers guarantee wr_addr is in range whenever we is high.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Registered read; addresses beyond the array read as zero.
  always_ff @(posedge clk) begin
    if ({1'b0, rd_addr} < DEPTH_L) begin
      rd_data <= mem[rd_addr];
    end else begin
      rd_data <= {WIDTH{1'b0}};
    end
  end

endmodule

// File: rtl/dm_sync.sv
// Synchronous data memory with Ready handshake, post-reset clear sweep and write abort.
// Optional stored-parity check is enabled by defining DM_PARITY_EN (adds ParErr port).
module dm_sync
  import dm_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int ADDR_W  = 8,
  parameter int DEPTH   = 256,
  parameter int RD_WAIT = 1,
  parameter int WR_WAIT = 3
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] ABUS,
  input  logic [DATA_W-1:0] DIN,
  output logic [DATA_W-1:0] DATABUS,
  output logic              Ready,
  output logic              Busy,
  output logic              WrAbort
`ifdef DM_PARITY_EN
  ,
  output logic              ParErr
`endif
);

`ifdef DM_PARITY_EN
  localparam int MEM_W = DATA_W + 1;
`else
  localparam int MEM_W = DATA_W;
`endif

  localparam logic [ADDR_W:0]         DEPTH_L  = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W-1:0]       LAST_PTR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0]       ADDR_ONE = ADDR_W'(1);
  localparam logic [WAIT_CNT_W-1:0]   CNT_ONE  = WAIT_CNT_W'(1);
  localparam logic [WAIT_CNT_W-1:0]   CNT_ZERO = WAIT_CNT_W'(0);

  if (RD_WAIT < 0 || RD_WAIT > 15 || WR_WAIT < 0 || WR_WAIT > 15) begin : g_wait_range_err
    $error("dm_sync: RD_WAIT and WR_WAIT must be in 0..15");
  end
  if (DEPTH < 1 || DEPTH > (1 << ADDR_W)) begin : g_depth_range_err
    $error("dm_sync: DEPTH must be in 1..2**ADDR_W");
  end

  state_t                  state_r;
  state_t                  state_s;
  logic [WAIT_CNT_W-1:0]   cnt_r;
  logic [ADDR_W-1:0]       addr_r;
  logic [DATA_W-1:0]       din_r;
  logic [ADDR_W-1:0]       clr_ptr_r;

  logic                    done_s;
  logic                    in_range_s;
  logic                    wr_en_s;
  logic [ADDR_W-1:0]       wr_addr_s;
  logic [MEM_W-1:0]        wr_data_s;
  logic [ADDR_W-1:0]       rd_addr_s;
  logic [MEM_W-1:0]        rd_data_s;

  assign done_s     = (cnt_r == CNT_ZERO);
  assign in_range_s = ({1'b0, addr_r} < DEPTH_L);
  // In IDLE the array pre-reads the live bus so a zero-wait read still completes one edge later.
  assign rd_addr_s  = (state_r == IDLE) ? ABUS : addr_r;

  // Next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      CLEAR: begin
        if (clr_ptr_r == LAST_PTR) state_s = IDLE;
        else                       state_s = CLEAR;
      end
      IDLE: begin
        if (MemWrite)     state_s = WR;
        else if (MemRead) state_s = RD;
        else              state_s = IDLE;
      end
      RD, WR: begin
        if (done_s) state_s = IDLE;
        else        state_s = state_r;
      end
      default: state_s = CLEAR;
    endcase
  end

  // Array write-port mux: clear sweep or a committed (held, in-range) write.
  always_comb begin
    wr_en_s   = 1'b0;
    wr_addr_s = addr_r;
    wr_data_s = {MEM_W{1'b0}};
    case (state_r)
      CLEAR: begin
        wr_en_s   = 1'b1;
        wr_addr_s = clr_ptr_r;
        wr_data_s = {MEM_W{1'b0}};
      end
      WR: begin
        wr_en_s   = done_s && MemWrite && in_range_s;
        wr_addr_s = addr_r;
`ifdef DM_PARITY_EN
        wr_data_s = {parity_even(64'(din_r)), din_r};
`else
        wr_data_s = din_r;
`endif
      end
      default: begin
        wr_en_s   = 1'b0;
        wr_addr_s = addr_r;
        wr_data_s = {MEM_W{1'b0}};
      end
    endcase
  end

  // FSM state, request latches, wait counter and registered outputs.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r   <= CLEAR;
      clr_ptr_r <= {ADDR_W{1'b0}};
      cnt_r     <= CNT_ZERO;
      addr_r    <= {ADDR_W{1'b0}};
      din_r     <= {DATA_W{1'b0}};
      DATABUS   <= {DATA_W{1'b0}};
      Ready     <= 1'b0;
      WrAbort   <= 1'b0;
      Busy      <= 1'b1;
`ifdef DM_PARITY_EN
      ParErr    <= 1'b0;
`endif
    end else begin
      state_r <= state_s;
      Busy    <= (state_s != IDLE);
      Ready   <= 1'b0;
      WrAbort <= 1'b0;
`ifdef DM_PARITY_EN
      ParErr  <= 1'b0;
`endif
      case (state_r)
        CLEAR: clr_ptr_r <= clr_ptr_r + ADDR_ONE;
        IDLE: begin
          if (MemWrite) begin
            addr_r <= ABUS;
            din_r  <= DIN;
            cnt_r  <= WAIT_CNT_W'(WR_WAIT);
          end else if (MemRead) begin
            addr_r <= ABUS;
            cnt_r  <= WAIT_CNT_W'(RD_WAIT);
          end else begin
            cnt_r  <= cnt_r;
          end
        end
        RD: begin
          if (done_s) begin
            DATABUS <= rd_data_s[DATA_W-1:0];
            Ready   <= 1'b1;
`ifdef DM_PARITY_EN
            ParErr  <= in_range_s &&
                       (rd_data_s[DATA_W] != parity_even(64'(rd_data_s[DATA_W-1:0])));
`endif
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        WR: begin
          // MemWrite is only sampled on the final edge; dropping it earlier still aborts here.
          if (done_s) begin
            if (MemWrite) Ready   <= 1'b1;
            else          WrAbort <= 1'b1;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        default: state_r <= CLEAR;
      endcase
    end
  end

  dm_ram_array #(
    .WIDTH  (MEM_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk     (CLK),
    .we      (wr_en_s),
    .wr_addr (wr_addr_s),
    .wr_data (wr_data_s),
    .rd_addr (rd_addr_s),
    .rd_data (rd_data_s)
  );

endmodule

// File: tb/tb_dm_sync.sv
// Scoreboard bench for dm_sync: directed accesses push expected completions, a monitor checks them.
module tb_dm_sync;

  localparam int DW = 8;
  localparam int AW = 8;
  localparam int DEP = 256;
  localparam int RW = 1;
  localparam int WW = 3;

  localparam int K_READ  = 0;
  localparam int K_WRITE = 1;
  localparam int K_ABORT = 2;

  typedef struct {
    int         kind;
    logic [7:0] data;
    int         cyc;
    logic       par;
  } exp_t;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          MemRead = 1'b0;
  logic          MemWrite = 1'b0;
  logic [AW-1:0] ABUS = 8'h00;
  logic [DW-1:0] DIN = 8'h00;
  logic [DW-1:0] DATABUS;
  logic          Ready;
  logic          Busy;
  logic          WrAbort;
`ifdef DM_PARITY_EN
  logic          ParErr;
`endif

  exp_t       q[$];
  int         n_checks = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic [7:0] last_db = 8'h00;

  dm_sync #(
    .DATA_W (DW), .ADDR_W (AW), .DEPTH (DEP), .RD_WAIT (RW), .WR_WAIT (WW)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .MemRead  (MemRead),
    .MemWrite (MemWrite),
    .ABUS     (ABUS),
    .DIN      (DIN),
    .DATABUS  (DATABUS),
    .Ready    (Ready),
    .Busy     (Busy),
    .WrAbort  (WrAbort)
`ifdef DM_PARITY_EN
    ,
    .ParErr   (ParErr)
`endif
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic void push(input int kind, input logic [7:0] d, input int c, input logic p);
    exp_t e;
    e.kind = kind;
    e.data = d;
    e.cyc  = c;
    e.par  = p;
    q.push_back(e);
  endfunction

  // Monitor: every completion pulse is matched against the oldest expected response.
  always @(negedge CLK) begin
    exp_t e;
    if (!RESET && (Ready || WrAbort)) begin
      if (q.size() == 0) begin
        check("unexpected_pulse", {30'd0, Ready, WrAbort}, 32'd0);
      end else begin
        e = q.pop_front();
        check("ready", {31'd0, Ready}, {31'd0, (e.kind != K_ABORT)});
        check("wrabort", {31'd0, WrAbort}, {31'd0, (e.kind == K_ABORT)});
        check("databus", {24'd0, DATABUS}, {24'd0, e.data});
        check("latency_cycle", cyc, e.cyc);
`ifdef DM_PARITY_EN
        check("parerr", {31'd0, ParErr}, {31'd0, (e.kind == K_READ) && e.par});
`endif
      end
    end
  end

  task automatic wait_done(input string name);
    int n = 0;
    while (!(Ready || WrAbort) && n < 64) begin
      @(negedge CLK);
      n++;
    end
    if (!(Ready || WrAbort)) check({name, "_timeout"}, 32'd0, 32'd1);
    MemRead  = 1'b0;
    MemWrite = 1'b0;
  endtask

  task automatic do_read(input logic [7:0] a, input logic [7:0] d, input logic p);
    @(negedge CLK);
    MemRead = 1'b1;
    ABUS    = a;
    push(K_READ, d, cyc + 2 + RW, p);
    last_db = d;
    @(negedge CLK);
    ABUS = ~a;
    wait_done("read");
  endtask

  task automatic do_write(input logic [7:0] a, input logic [7:0] d, input logic abort,
                          input logic with_read);
    @(negedge CLK);
    MemWrite = 1'b1;
    MemRead  = with_read;
    ABUS     = a;
    DIN      = d;
    push(abort ? K_ABORT : K_WRITE, last_db, cyc + 2 + WW, 1'b0);
    @(negedge CLK);
    ABUS = ~a;
    DIN  = ~d;
    if (abort) begin
      @(negedge CLK);
      MemWrite = 1'b0;
    end
    wait_done(abort ? "abort" : "write");
  endtask

  task automatic sweep_len(input int c0);
    int n = 0;
    while (Busy && n < 400) begin
      @(negedge CLK);
      n++;
    end
    check("busy_sweep_cycles", cyc - c0, 32'd256);
  endtask

  initial begin
    int c0;
    repeat (3) @(negedge CLK);
    check("rst_databus", {24'd0, DATABUS}, 32'd0);
    check("rst_ready", {31'd0, Ready}, 32'd0);
    check("rst_wrabort", {31'd0, WrAbort}, 32'd0);
    check("rst_busy", {31'd0, Busy}, 32'd1);

    // Requests during the sweep must be ignored, not queued.
    RESET    = 1'b0;
    c0       = cyc;
    MemWrite = 1'b1;
    ABUS     = 8'h7F;
    DIN      = 8'hEE;
    repeat (10) @(negedge CLK);
    MemWrite = 1'b0;
    sweep_len(c0);

    do_read(8'h00, 8'h00, 1'b0);
    do_read(8'h7F, 8'h00, 1'b0);
    do_read(8'hFF, 8'h00, 1'b0);

    do_write(8'h3C, 8'hA5, 1'b0, 1'b0);
    do_read(8'h3C, 8'hA5, 1'b0);

    do_write(8'h10, 8'h5A, 1'b1, 1'b0);
    do_read(8'h10, 8'h00, 1'b0);

    do_write(8'h20, 8'h77, 1'b0, 1'b1);
    do_read(8'h20, 8'h77, 1'b0);

    // Reset in the middle of a write: no Ready, no partial write, sweep restarts.
    @(negedge CLK);
    MemWrite = 1'b1;
    ABUS     = 8'h05;
    DIN      = 8'hFF;
    repeat (2) @(negedge CLK);
    RESET    = 1'b1;
    MemWrite = 1'b0;
    @(negedge CLK);
    check("midrst_busy", {31'd0, Busy}, 32'd1);
    check("midrst_databus", {24'd0, DATABUS}, 32'd0);
    RESET   = 1'b0;
    c0      = cyc;
    last_db = 8'h00;
    sweep_len(c0);
    do_read(8'h05, 8'h00, 1'b0);

`ifdef DM_PARITY_EN
    do_write(8'h02, 8'h01, 1'b0, 1'b0);
    dut.u_ram.mem[2][8] = ~dut.u_ram.mem[2][8];
    do_read(8'h02, 8'h01, 1'b1);
`endif

    repeat (6) @(negedge CLK);
    check("queue_drained", q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
